uart_rx: RTL and testbench

UART receiver for 8N1 serial frames, the receive counterpart of the existing transmit block. It synchronizes the asynchronous `rx` pin and finds the start bit. It samples each bit at mid-period, then delivers each byte with a single-cycle valid strobe to the downstream ECG filter and command logic. It flags frames whose stop bit is low, and it recovers cleanly from glitches and line breaks.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync2.sv | 32 +++
 rtl/uart_rx.sv | 141 ++++++++++++++
 tb/tb_uart_rx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART blocks.
// Frame format is fixed at 8N1.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int unsigned DEF_CLK_FREQ  = 50_000_000;
  localparam int unsigned DEF_BAUD_RATE = 115_200;
  localparam int unsigned DATA_BITS     = 8;
  localparam int unsigned STOP_BITS     = 1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both stages reset to RST_VAL so an idle line reads idle out of reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic d,
  output logic q
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid/error strobes,
// glitch rejection and break handling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = DEF_CLK_FREQ,
  parameter int BAUD_RATE   = DEF_BAUD_RATE,
  parameter int BIT_PERIOD  = CLK_FREQ / BAUD_RATE,
  parameter int HALF_PERIOD = BIT_PERIOD / 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam logic [15:0] BIT_TC  = 16'(BIT_PERIOD - 1);
  localparam logic [15:0] HALF_TC = 16'(HALF_PERIOD - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  logic rx_s;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .Clk (Clk),
    .Rst (Rst),
    .d   (rx),
    .q   (rx_s)
  );

  rx_state_t   state_d, state_q;
  logic [15:0] clk_count_d, clk_count_q;
  logic [2:0]  bit_index_d, bit_index_q;
  logic [7:0]  shift_reg_d, shift_reg_q;
  logic [7:0]  rx_data_d, rx_data_q;
  logic        rx_valid_d, rx_valid_q;
  logic        frame_err_d, frame_err_q;
  logic        rx_busy_d, rx_busy_q;
  logic        armed_d, armed_q;

  always_comb begin
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_index_d = bit_index_q;
    shift_reg_d = shift_reg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    // A start edge only counts once the line has been seen high after reset
    armed_d     = armed_q | rx_s;

    unique case (state_q)
      IDLE: begin
        clk_count_d = '0;
        bit_index_d = '0;
        if (!rx_s && armed_q) begin
          state_d = START;
        end
      end
      START: begin
        if (clk_count_q == HALF_TC) begin
          clk_count_d = '0;
          bit_index_d = '0;
          state_d     = rx_s ? IDLE : DATA;
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end
      DATA: begin
        if (clk_count_q == BIT_TC) begin
          clk_count_d = '0;
          shift_reg_d[bit_index_q] = rx_s;
          if (bit_index_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end
      STOP: begin
        if (clk_count_q == BIT_TC) begin
          clk_count_d = '0;
          if (rx_s) begin
            rx_data_d  = shift_reg_q;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rx_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      clk_count_q <= '0;
      bit_index_q <= '0;
      shift_reg_q <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_index_q <= bit_index_d;
      shift_reg_q <= shift_reg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
      armed_q     <= armed_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame table plus glitch, break
// and mid-frame reset sequences at default 115200 baud.
module tb_uart_rx;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  uart_rx dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 Clk = ~Clk;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int vcount    = 0;
  int ecount    = 0;
  int valid_cyc = 0;
  int fall_cyc  = 0;

  typedef struct {
    logic [7:0] data;
    int         per;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got,
                             input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_data"},  int'(rx_data),   0);
    check({tag, "_valid"}, int'(rx_valid),  0);
    check({tag, "_err"},   int'(frame_err), 0);
    check({tag, "_busy"},  int'(rx_busy),   0);
  endtask

  // Called at a negedge; returns at the negedge ending the stop bit
  task automatic send_byte(input logic [7:0] b, input int per,
                           input logic stop);
    rx = 1'b0;
    fall_cyc = cyc;
    repeat (per) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (per) @(negedge Clk);
    end
    rx = stop;
    repeat (per) @(negedge Clk);
  endtask

  task automatic good_frame(input string name, input logic [7:0] b,
                            input int per);
    int v0, e0;
    v0 = vcount;
    e0 = ecount;
    send_byte(b, per, 1'b1);
    check({name, "_vcnt"}, vcount, v0 + 1);
    check({name, "_data"}, int'(rx_data), int'(b));
    check({name, "_ecnt"}, ecount, e0);
    check({name, "_idle"}, int'(rx_busy), 0);
  endtask

  always @(posedge Clk) cyc = cyc + 1;

  always @(negedge Clk) begin
    if (!Rst && (rx_valid || frame_err)) begin
      check("strobe_excl", int'(rx_valid && frame_err), 0);
      if (rx_valid) begin
        vcount++;
        valid_cyc = cyc;
      end
      if (frame_err) ecount++;
    end
  end

  initial begin
    int v0, e0, c0;

    vecs[0] = '{8'hA5, 434};
    vecs[1] = '{8'h00, 434};
    vecs[2] = '{8'hFF, 434};
    vecs[3] = '{8'h3C, 434};
    vecs[4] = '{8'h96, 421};
    vecs[5] = '{8'h96, 447};

    Rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge Clk);
    check_reset_outs("rst");
    Rst = 1'b0;
    repeat (5) @(negedge Clk);

    for (int i = 0; i < 6; i++) begin
      good_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].per);
      if (i == 0) begin
        check_range("latency", valid_cyc - fall_cyc, 4120, 4126);
      end
    end

    // 100-clock glitch on an idle line
    repeat (20) @(negedge Clk);
    v0 = vcount;
    e0 = ecount;
    rx = 1'b0;
    repeat (100) @(negedge Clk);
    rx = 1'b1;
    repeat (110) @(negedge Clk);
    check("glitch_busy_hi", int'(rx_busy), 1);
    repeat (20) @(negedge Clk);
    check("glitch_busy_lo", int'(rx_busy), 0);
    check("glitch_vcnt", vcount, v0);
    check("glitch_ecnt", ecount, e0);
    good_frame("after_glitch", 8'h5A, 434);

    // Bad stop bit followed by a break
    v0 = vcount;
    e0 = ecount;
    send_byte(8'h81, 434, 1'b0);
    repeat (2000) @(negedge Clk);
    check("brk_ecnt", ecount, e0 + 1);
    check("brk_vcnt", vcount, v0);
    check("brk_data", int'(rx_data), 'h5A);
    check("brk_busy", int'(rx_busy), 1);
    rx = 1'b1;
    @(negedge Clk);
    check("brk_busy_hold", int'(rx_busy), 1);
    repeat (4) @(negedge Clk);
    check("brk_busy_rel", int'(rx_busy), 0);
    good_frame("after_brk", 8'h42, 434);

    // Reset during data bit 4 of a frame
    v0 = vcount;
    e0 = ecount;
    fork
      send_byte(8'hF0, 434, 1'b1);
      begin
        repeat (2300) @(negedge Clk);
        Rst = 1'b1;
        #1;
        check_reset_outs("midrst");
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
      end
    join
    check("midrst_vcnt", vcount, v0);
    check("midrst_ecnt", ecount, e0);
    check("midrst_busy", int'(rx_busy), 0);
    repeat (10) @(negedge Clk);
    c0 = vcount;
    good_frame("after_rst", 8'hC3, 434);
    check("total_valid", c0, 17 - 17 + v0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
